phase1_cell_scheduler: RTL and testbench
========================================

// Module: phase1_cell_scheduler
// PURPOSE
//  Sequences Phase 1 (force computation) for one timestep: walks every home cell and its
//  14 half-shell neighbour cells, issuing one (home,nbr) cell pair per handshake to the
//  force pipeline. Waits for the pipeline to drain, then raises phase1_done to the phase controller.
//  Sits between the phase controller (phase1_ready/phase1_done) and the pair-filter/force datapath.
// PARAMETERS
//  CX_W          2   log2 cells in x (grid is 2^CX_W cells, periodic)
//  CY_W          2   log2 cells in y
//  CZ_W          2   log2 cells in z
//  DRAIN_CYCLES  16  minimum cycles after last pair before pipe_idle is honoured
// PORTS
//  clk           in   1        system clock
//  reset         in   1        asynchronous, active-high reset
//  phase1_ready  in   1        level from phase controller; high = Phase 1 active
//  double_buffer in   1        position-bank select from phase controller
//  phase1_done   out  1        high in DONE until phase1_ready falls
//  pair_valid    out  1        pair outputs valid
//  pair_ready    in   1        datapath accepts pair (fire = valid & ready)
//  home_cell     out  CX_W+CY_W+CZ_W  {z,y,x} home cell coordinate
//  nbr_cell      out  CX_W+CY_W+CZ_W  {z,y,x} neighbour cell coordinate (wrapped)
//  last_pair     out  1        qualifies final pair of the step (with pair_valid)
//  pos_bank      out  1        double_buffer latched at phase start; stable through phase
//  pipe_idle     in   1        force pipeline empty, no results in flight
//  busy          out  1        state != IDLE
//  proto_err     out  1        sticky: phase1_ready fell while ISSUE or DRAIN
//  phase_cycles  out  32       cycles spent in last completed phase (ISSUE entry to DONE entry)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; offset idx, cell counters, drain counter 0.
//  - States: IDLE -> ISSUE on phase1_ready=1 (pos_bank <= double_buffer, counters cleared).
//    ISSUE -> DRAIN on fire of last pair. DRAIN -> DONE when drain_cnt >= DRAIN_CYCLES
//    and pipe_idle=1 in the same cycle. DONE -> IDLE when phase1_ready=0.
//  - pair_valid is registered, high every ISSUE cycle; first pair valid 1 cycle after IDLE exit.
//    Outputs change only on fire; held stable while valid & !ready. Zero bubbles between fires.
//  - Order: offset index (0..13) innermost, then home x, y, z. Total pairs = 14*2^(CX_W+CY_W+CZ_W).
//  - Offsets {dx,dy,dz}: 0:(0,0,0) 1:(1,0,0) 2:(-1,1,0) 3:(0,1,0) 4:(1,1,0),
//    5..13:(dx,dy,1) dx fastest over -1..1, dy over -1..1.
//  - nbr = home + offset per axis modulo 2^AXIS_W (natural truncation; periodic wrap).
//  - last_pair = 1 only for home=all-ones, offset 13.
//  - drain_cnt clears on DRAIN entry, saturates at DRAIN_CYCLES; pipe_idle ignored before that.
//  - phase1_done asserted on DONE entry, held until phase1_ready low; no re-trigger while high.
//  - phase1_ready low in ISSUE/DRAIN: proto_err <= 1 (sticky until reset); sequencing continues.
//  - phase_cycles: free counter cleared on ISSUE entry, copied on DONE entry; 32-bit wrap.
//  - Reset mid-operation: immediate return to IDLE, pair_valid drops asynchronously.
// STRUCTURE
//  - Shared include md_params.vh: N_NEIGHBORS=14, state encodings, half-shell offset table.
//  - Sub-module half_shell_offset_rom: 4-bit index -> signed 2-bit dx,dy,dz (combinational).
//  - Top: FSM, offset/cell counters, wrap adders, drain counter, cycle counter.
// TESTING (bench CX_W=CY_W=CZ_W=1, DRAIN_CYCLES=4 unless noted)
//  1. reset, phase1_ready=1, pair_ready=1 -> 112 fires on consecutive cycles; first pair
//     home=0 nbr=0; pair 2 nbr={0,0,1}; last_pair only on pair 112 (home=7, nbr={0,0,0}).
//  2. home=0 offset 2 (-1,1,0) -> nbr={z0,y1,x1}; default widths home=63 offset 13 -> nbr=0.
//  3. pair_ready toggled randomly -> outputs stable while stalled; still exactly 112 fires, in order.
//  4. pipe_idle=0 for 10 cycles after last fire -> phase1_done rises only after pipe_idle=1;
//     pipe_idle=1 throughout -> done 4 cycles after DRAIN entry (+1 registration).
//  5. double_buffer toggles mid-phase -> pos_bank unchanged; phase1_ready low in ISSUE -> proto_err=1.
//  6. reset pulse mid-ISSUE -> all outputs 0; next phase1_ready restarts from home=0 offset 0.

Source files
------------

// File: rtl/phase1_cell_scheduler_pkg.sv
// Shared constants for the Phase 1 cell scheduler: FSM encodings, the
// half-shell neighbour count and the half-shell offset table.
package phase1_cell_scheduler_pkg;

    localparam int         N_NEIGHBORS = 14;
    localparam logic [3:0] LAST_OFFSET = 4'd13;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic signed [1:0] OFF_M1 = 2'sb11;
    localparam logic signed [1:0] OFF_Z  = 2'sb00;
    localparam logic signed [1:0] OFF_P1 = 2'sb01;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
        logic signed [1:0] dz;
    } offset_t;

    // Half-shell table: the five dz=0 neighbours first, then the dz=+1 plane
    // with dx varying fastest and dy slowest, each over -1..+1.
    function automatic offset_t half_shell_offset(input logic [3:0] idx);
        offset_t o;
        case (idx)
            4'd0:    o = '{OFF_Z,  OFF_Z,  OFF_Z};
            4'd1:    o = '{OFF_P1, OFF_Z,  OFF_Z};
            4'd2:    o = '{OFF_M1, OFF_P1, OFF_Z};
            4'd3:    o = '{OFF_Z,  OFF_P1, OFF_Z};
            4'd4:    o = '{OFF_P1, OFF_P1, OFF_Z};
            4'd5:    o = '{OFF_M1, OFF_M1, OFF_P1};
            4'd6:    o = '{OFF_Z,  OFF_M1, OFF_P1};
            4'd7:    o = '{OFF_P1, OFF_M1, OFF_P1};
            4'd8:    o = '{OFF_M1, OFF_Z,  OFF_P1};
            4'd9:    o = '{OFF_Z,  OFF_Z,  OFF_P1};
            4'd10:   o = '{OFF_P1, OFF_Z,  OFF_P1};
            4'd11:   o = '{OFF_M1, OFF_P1, OFF_P1};
            4'd12:   o = '{OFF_Z,  OFF_P1, OFF_P1};
            4'd13:   o = '{OFF_P1, OFF_P1, OFF_P1};
            default: o = '{OFF_Z,  OFF_Z,  OFF_Z};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/phase1_cell_scheduler_offset_rom.sv
// Combinational half-shell offset ROM: 4-bit neighbour index to signed
// per-axis cell offsets.
module phase1_cell_scheduler_offset_rom
    import phase1_cell_scheduler_pkg::*;
(
    input  logic              [3:0] idx,
    output logic signed       [1:0] dx,
    output logic signed       [1:0] dy,
    output logic signed       [1:0] dz
);

    offset_t off_s;

    // Table lookup of the neighbour offset for the requested index.
    always_comb begin
        off_s = half_shell_offset(idx);
    end

    assign dx = off_s.dx;
    assign dy = off_s.dy;
    assign dz = off_s.dz;

endmodule

// File: rtl/phase1_cell_scheduler.sv
// Phase 1 cell scheduler: walks every home cell and its 14 half-shell
// neighbours, handing one (home, neighbour) pair per handshake to the force
// pipeline, then waits for the pipeline to drain before signalling done.
module phase1_cell_scheduler
    import phase1_cell_scheduler_pkg::*;
#(
    parameter int CX_W         = 2,
    parameter int CY_W         = 2,
    parameter int CZ_W         = 2,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        phase1_ready,
    input  logic                        double_buffer,
    output logic                        phase1_done,
    output logic                        pair_valid,
    input  logic                        pair_ready,
    output logic [CX_W+CY_W+CZ_W-1:0]   home_cell,
    output logic [CX_W+CY_W+CZ_W-1:0]   nbr_cell,
    output logic                        last_pair,
    output logic                        pos_bank,
    input  logic                        pipe_idle,
    output logic                        busy,
    output logic                        proto_err,
    output logic [31:0]                 phase_cycles
);

    localparam int                  CELL_W    = CX_W + CY_W + CZ_W;
    localparam int                  DCNT_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DCNT_W-1:0]   DRAIN_MAX = DCNT_W'(DRAIN_CYCLES);
    localparam logic [CELL_W-1:0]   HOME_ONE  = {{(CELL_W-1){1'b0}}, 1'b1};
    localparam logic [CELL_W-1:0]   HOME_LAST = {CELL_W{1'b1}};

    logic [1:0]         state_r, state_n_s;
    logic [3:0]         off_idx_r, off_n_s;
    logic [CELL_W-1:0]  home_r, home_n_s, nbr_r, nbr_n_s;
    logic               last_r, last_n_s;
    logic               valid_r, bank_r, done_r, busy_r, perr_r;
    logic [DCNT_W-1:0]  drain_cnt_r;
    logic [31:0]        cyc_r, phase_cycles_r;
    logic               fire_s, start_s, advance_s, drain_enter_s, done_enter_s;
    logic signed [1:0]  dx_s, dy_s, dz_s;

    assign fire_s        = valid_r & pair_ready;
    assign drain_enter_s = (state_r == ST_ISSUE) && (state_n_s == ST_DRAIN);
    assign done_enter_s  = (state_r == ST_DRAIN) && (state_n_s == ST_DONE);

    // Next-state logic and the strobes that load or advance the pair counters.
    always_comb begin
        state_n_s = state_r;
        start_s   = 1'b0;
        advance_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (phase1_ready) begin
                    state_n_s = ST_ISSUE;
                    start_s   = 1'b1;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (fire_s && last_r) begin
                    state_n_s = ST_DRAIN;
                end else if (fire_s) begin
                    advance_s = 1'b1;
                end else begin
                    state_n_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if ((drain_cnt_r >= DRAIN_MAX) && pipe_idle) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!phase1_ready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DONE;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Next pair position: offset index innermost, then the {z,y,x} home
    // counter, which carries x into y into z by plain binary increment.
    always_comb begin
        off_n_s  = off_idx_r;
        home_n_s = home_r;
        if (start_s) begin
            off_n_s  = 4'd0;
            home_n_s = {CELL_W{1'b0}};
        end else if (advance_s) begin
            if (off_idx_r == LAST_OFFSET) begin
                off_n_s  = 4'd0;
                home_n_s = home_r + HOME_ONE;
            end else begin
                off_n_s  = off_idx_r + 4'd1;
                home_n_s = home_r;
            end
        end else begin
            off_n_s  = off_idx_r;
            home_n_s = home_r;
        end
    end

    phase1_cell_scheduler_offset_rom u_offset_rom (
        .idx (off_n_s),
        .dx  (dx_s),
        .dy  (dy_s),
        .dz  (dz_s)
    );

    // Periodic wrap: the size casts fold the signed offset into each axis
    // width, and the per-axis sum drops its carry.
    always_comb begin
        nbr_n_s  = {home_n_s[CELL_W-1:CX_W+CY_W] + CZ_W'(dz_s),
                    home_n_s[CX_W+CY_W-1:CX_W]   + CY_W'(dy_s),
                    home_n_s[CX_W-1:0]           + CX_W'(dx_s)};
        last_n_s = (home_n_s == HOME_LAST) && (off_n_s == LAST_OFFSET);
    end

    // FSM state, handshake outputs and the registered pair presented downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            bank_r    <= 1'b0;
            perr_r    <= 1'b0;
            off_idx_r <= 4'd0;
            home_r    <= {CELL_W{1'b0}};
            nbr_r     <= {CELL_W{1'b0}};
            last_r    <= 1'b0;
        end else begin
            state_r <= state_n_s;
            valid_r <= (state_n_s == ST_ISSUE);
            busy_r  <= (state_n_s != ST_IDLE);
            done_r  <= (state_n_s == ST_DONE);
            if (start_s) begin
                bank_r <= double_buffer;
            end
            if (((state_r == ST_ISSUE) || (state_r == ST_DRAIN)) && !phase1_ready) begin
                perr_r <= 1'b1;
            end
            if (start_s || advance_s) begin
                off_idx_r <= off_n_s;
                home_r    <= home_n_s;
                nbr_r     <= nbr_n_s;
                last_r    <= last_n_s;
            end else if (state_n_s != ST_ISSUE) begin
                last_r    <= 1'b0;
            end
        end
    end

    // Drain delay counter and the per-phase cycle measurement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_cnt_r    <= {DCNT_W{1'b0}};
            cyc_r          <= 32'd0;
            phase_cycles_r <= 32'd0;
        end else begin
            if (drain_enter_s) begin
                drain_cnt_r <= {DCNT_W{1'b0}};
            end else if ((state_r == ST_DRAIN) && (drain_cnt_r < DRAIN_MAX)) begin
                drain_cnt_r <= drain_cnt_r + {{(DCNT_W-1){1'b0}}, 1'b1};
            end
            if (start_s) begin
                cyc_r <= 32'd0;
            end else if ((state_r == ST_ISSUE) || (state_r == ST_DRAIN)) begin
                cyc_r <= cyc_r + 32'd1;
            end
            if (done_enter_s) begin
                phase_cycles_r <= cyc_r + 32'd1;
            end
        end
    end

    assign pair_valid   = valid_r;
    assign home_cell    = home_r;
    assign nbr_cell     = nbr_r;
    assign last_pair    = last_r;
    assign pos_bank     = bank_r;
    assign phase1_done  = done_r;
    assign busy         = busy_r;
    assign proto_err    = perr_r;
    assign phase_cycles = phase_cycles_r;

endmodule

// File: tb/tb_phase1_cell_scheduler.sv
// Directed bench for phase1_cell_scheduler: a 2x2x2 grid instance with a
// short drain, plus a default-width instance for the large-grid wrap case.
module tb_phase1_cell_scheduler;

    logic        clk;
    logic        reset;
    logic        phase1_ready;
    logic        double_buffer;
    logic        pair_ready;
    logic        pipe_idle;
    logic        phase1_done;
    logic        pair_valid;
    logic [2:0]  home_cell;
    logic [2:0]  nbr_cell;
    logic        last_pair;
    logic        pos_bank;
    logic        busy;
    logic        proto_err;
    logic [31:0] phase_cycles;

    logic        ready_d;
    logic        done_d, valid_d, last_d, bank_d, busy_d, perr_d;
    logic [5:0]  home_d, nbr_d;
    logic [31:0] cycles_d;

    int checks = 0;
    int errors = 0;

    int dx_t [14] = '{0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1};
    int dy_t [14] = '{0, 0, 1, 1, 1, -1, -1, -1, 0, 0, 0, 1, 1, 1};
    int dz_t [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    phase1_cell_scheduler #(.CX_W(1), .CY_W(1), .CZ_W(1), .DRAIN_CYCLES(4)) u_dut (
        .clk(clk), .reset(reset), .phase1_ready(phase1_ready), .double_buffer(double_buffer),
        .phase1_done(phase1_done), .pair_valid(pair_valid), .pair_ready(pair_ready),
        .home_cell(home_cell), .nbr_cell(nbr_cell), .last_pair(last_pair), .pos_bank(pos_bank),
        .pipe_idle(pipe_idle), .busy(busy), .proto_err(proto_err), .phase_cycles(phase_cycles)
    );

    phase1_cell_scheduler u_dut_def (
        .clk(clk), .reset(reset), .phase1_ready(ready_d), .double_buffer(double_buffer),
        .phase1_done(done_d), .pair_valid(valid_d), .pair_ready(pair_ready),
        .home_cell(home_d), .nbr_cell(nbr_d), .last_pair(last_d), .pos_bank(bank_d),
        .pipe_idle(pipe_idle), .busy(busy_d), .proto_err(perr_d), .phase_cycles(cycles_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_nbr(input int k);
        int h, o, nx, ny, nz;
        h  = k / 14;
        o  = k % 14;
        nx = ((h & 1) + dx_t[o]) & 1;
        ny = (((h >> 1) & 1) + dy_t[o]) & 1;
        nz = (((h >> 2) & 1) + dz_t[o]) & 1;
        return 32'(nz * 4 + ny * 2 + nx);
    endfunction

    // Presents pairs until stop_at fires have been issued; every cycle the
    // current pair must be the k-th one in walk order.
    task automatic run_issue(input bit rnd, input int flip_at, input int drop_at,
                             input logic exp_bank, input int stop_at);
        int k = 0;
        int cyc = 0;
        bit flipped = 1'b0;
        bit dropped = 1'b0;
        while (k < stop_at && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            phase1_ready = 1'b1;
            chk("pair_valid", 32'(pair_valid), 32'd1);
            chk("home_cell", 32'(home_cell), 32'(k / 14));
            chk("nbr_cell", 32'(nbr_cell), exp_nbr(k));
            chk("last_pair", 32'(last_pair), (k == 111) ? 32'd1 : 32'd0);
            chk("pos_bank", 32'(pos_bank), 32'(exp_bank));
            if (k == flip_at && !flipped) begin
                double_buffer = ~double_buffer;
                flipped = 1'b1;
            end
            if (k == drop_at && !dropped) begin
                phase1_ready = 1'b0;
                dropped = 1'b1;
            end
            pair_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pair_ready) k++;
        end
        chk("fire_count", 32'(k), 32'(stop_at));
    endtask

    // Counts negedges after the final fire until phase1_done; pipe_idle is
    // raised at negedge idle_after when the pipeline is held busy.
    task automatic wait_done(input int exp_n, input int idle_after);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == idle_after) pipe_idle = 1'b1;
        end while (!phase1_done && n < 100);
        chk("done_latency", 32'(n), 32'(exp_n));
    endtask

    initial begin
        int c;
        int n;
        bit found;
        reset = 1'b1; phase1_ready = 1'b0; double_buffer = 1'b0;
        pair_ready = 1'b0; pipe_idle = 1'b1; ready_d = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(pair_valid), 32'd0);
        chk("rst_done", 32'(phase1_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_home", 32'(home_cell), 32'd0);
        chk("rst_nbr", 32'(nbr_cell), 32'd0);
        chk("rst_last", 32'(last_pair), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        chk("rst_cycles", phase_cycles, 32'd0);
        reset = 1'b0;

        // Phase A: full-rate issue, idle pipeline, bank 1.
        double_buffer = 1'b1; phase1_ready = 1'b1;
        run_issue(1'b0, -1, -1, 1'b1, 112);
        wait_done(6, 0);
        chk("a_phase_cycles", phase_cycles, 32'd117);
        chk("a_busy_done", 32'(busy), 32'd1);
        chk("a_valid_done", 32'(pair_valid), 32'd0);
        chk("a_last_done", 32'(last_pair), 32'd0);
        chk("a_perr", 32'(proto_err), 32'd0);
        repeat (3) @(negedge clk);
        chk("a_done_held", 32'(phase1_done), 32'd1);
        chk("a_no_retrigger", 32'(pair_valid), 32'd0);
        phase1_ready = 1'b0;
        @(negedge clk);
        chk("a_done_clear", 32'(phase1_done), 32'd0);
        chk("a_idle_busy", 32'(busy), 32'd0);

        // Phase B: random back-pressure, bank flip mid-phase, slow drain.
        double_buffer = 1'b0; pipe_idle = 1'b0; phase1_ready = 1'b1;
        run_issue(1'b1, 50, -1, 1'b0, 112);
        wait_done(11, 10);
        chk("b_pos_bank", 32'(pos_bank), 32'd0);
        chk("b_perr", 32'(proto_err), 32'd0);
        phase1_ready = 1'b0;
        @(negedge clk);

        // Phase C: phase1_ready glitch during issue.
        phase1_ready = 1'b1;
        run_issue(1'b0, -1, 20, 1'b1, 112);
        chk("c_perr_set", 32'(proto_err), 32'd1);
        wait_done(6, 0);
        chk("c_perr_sticky", 32'(proto_err), 32'd1);
        phase1_ready = 1'b0;
        @(negedge clk);

        // Phase D: asynchronous reset mid-issue, then a clean restart.
        phase1_ready = 1'b1;
        run_issue(1'b0, -1, -1, 1'b1, 30);
        #2 reset = 1'b1;
        #1;
        chk("d_rst_valid", 32'(pair_valid), 32'd0);
        chk("d_rst_busy", 32'(busy), 32'd0);
        chk("d_rst_home", 32'(home_cell), 32'd0);
        chk("d_rst_nbr", 32'(nbr_cell), 32'd0);
        chk("d_rst_perr", 32'(proto_err), 32'd0);
        chk("d_rst_bank", 32'(pos_bank), 32'd0);
        chk("d_rst_cycles", phase_cycles, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_issue(1'b0, -1, -1, 1'b1, 112);
        wait_done(6, 0);
        chk("d_phase_cycles", phase_cycles, 32'd117);
        phase1_ready = 1'b0;
        @(negedge clk);

        // Phase E: default 4x4x4 grid, wrap of the final pair.
        ready_d = 1'b1; pair_ready = 1'b1; pipe_idle = 1'b1;
        c = 0; n = 0; found = 1'b0;
        while (!found && n < 2000) begin
            @(negedge clk);
            n++;
            if (valid_d) begin
                if (c == 2) chk("def_nbr_off2", 32'(nbr_d), 32'd7);
                if (last_d) begin
                    found = 1'b1;
                    chk("def_last_home", 32'(home_d), 32'd63);
                    chk("def_last_nbr", 32'(nbr_d), 32'd0);
                    chk("def_last_index", 32'(c), 32'd895);
                end
                c++;
            end
        end
        chk("def_last_seen", 32'(found), 32'd1);
        ready_d = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
